// File: rtl/host_cmd_initiator_pkg.sv
// Shared types and helpers for the byte-serial device command initiator.
package host_cmd_initiator_pkg;

  typedef enum logic [3:0] {
    CMD_RESET = 4'd0,
    CMD_READ  = 4'd1,
    CMD_WRITE = 4'd2
  } cmd_id_t;

  localparam int CMD_ADDR_W  = 14;
  localparam int CMD_SIZE_W  = 14;
  localparam int CMD_REG_BIT = 13;
  localparam int DEV_MEM_TOP = 8191;

  typedef struct packed {
    logic [3:0]            cmd;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_SIZE_W-1:0] size;
  } req_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_LOAD,
    ST_CMD,
    ST_PAYLOAD,
    ST_RESP,
    ST_DONE
  } state_t;

  function automatic logic [31:0] pack_cmd(input logic [3:0]            id,
                                           input logic [CMD_ADDR_W-1:0] addr,
                                           input logic [CMD_SIZE_W-1:0] size);
    return {id, addr, size};
  endfunction

endpackage

// File: rtl/host_cmd_initiator_cmd_chunk_buf.sv
// Small register FIFO holding one write chunk so its payload can be streamed without gaps.
module cmd_chunk_buf #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic [CW-1:0] count,
  output logic          empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][7:0] mem;
  logic [PW-1:0]         wr_ptr, rd_ptr;

  // explicit wrap keeps the pointers correct for any depth, not just powers of two
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/host_cmd_initiator.sv
// Host-side initiator: splits a request into command-word chunks, streams payload, drains responses.
// Optional response watchdog enabled by defining CMD_INIT_TIMEOUT_EN.
module host_cmd_initiator
  import host_cmd_initiator_pkg::*;
#(
  parameter int MAX_BURST      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [3:0]  i_req_cmd,
  input  logic [13:0] i_req_addr,
  input  logic [13:0] i_req_size,
  input  logic        i_wr_valid,
  input  logic [7:0]  i_wr_data,
  output logic        o_wr_ready,
  output logic        o_tx_write,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_full,
  output logic        o_rx_read,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_empty,
  output logic        o_rd_valid,
  output logic [7:0]  o_rd_data,
  output logic        o_done,
  output logic        o_err
);
  localparam int CW = $clog2(MAX_BURST + 1);

  state_t        state_q, state_d;
  req_t          req_q;
  logic [12:0]   addr_q;
  logic [14:0]   rem_q;
  logic [1:0]    byte_q;
  logic [CW-1:0] rd_cnt_q, chunk, resp_len, buf_count;
  logic          err_q, rd_vld_q;
  logic [7:0]    rd_data_q, buf_data;
  logic          buf_push, buf_pop, buf_empty;
  logic          is_reg, is_mem, is_mem_wr, bad_req, chunk_end, tmo_hit, rx_pop, last_chunk;
  logic [14:0]   span_end;
  logic [31:0]   cmd_word;

  assign is_reg    = req_q.addr[CMD_REG_BIT];
  assign is_mem    = !is_reg && (req_q.cmd == CMD_READ || req_q.cmd == CMD_WRITE);
  assign is_mem_wr = is_mem && (req_q.cmd == CMD_WRITE);
  assign span_end  = 15'(req_q.addr[12:0]) + 15'(req_q.size);
  assign bad_req   = (req_q.cmd > CMD_WRITE) || (is_mem && span_end > 15'(DEV_MEM_TOP));

  assign chunk      = (rem_q > 15'(MAX_BURST)) ? CW'(MAX_BURST) : rem_q[CW-1:0];
  assign resp_len   = is_reg ? CW'(1) : chunk;
  assign last_chunk = is_reg || (rem_q == 15'(chunk));

  // memory ops carry the running chunk address/length; reset and register ops go out verbatim
  assign cmd_word = is_mem ? pack_cmd(req_q.cmd, {1'b0, addr_q}, 14'(chunk) - 14'd1)
                           : pack_cmd(req_q.cmd, req_q.addr, req_q.size);

  assign buf_push  = o_wr_ready && i_wr_valid;
  assign buf_pop   = (state_q == ST_PAYLOAD) && !i_tx_full && !buf_empty;
  assign rx_pop    = (state_q == ST_RESP) && !i_rx_empty;
  assign chunk_end = (buf_pop && buf_count == CW'(1)) ||
                     (rx_pop && rd_cnt_q == resp_len - 1'b1);

  cmd_chunk_buf #(.DEPTH(MAX_BURST), .CW(CW)) u_buf (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (buf_push),
    .wdata (i_wr_data),
    .pop   (buf_pop),
    .rdata (buf_data),
    .count (buf_count),
    .empty (buf_empty)
  );

`ifdef CMD_INIT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;

  assign tmo_hit = rx_pop ? 1'b0
                 : (state_q == ST_RESP) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                              tmo_q <= '0;
    else if (state_q != ST_RESP || rx_pop)  tmo_q <= '0;
    else                                    tmo_q <= tmo_q + 1'b1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    o_req_ready = 1'b0;
    o_wr_ready  = 1'b0;
    o_tx_write  = 1'b0;
    o_tx_data   = 8'h00;
    o_rx_read   = 1'b0;
    o_done      = 1'b0;
    o_err       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (bad_req)        state_d = ST_DONE;
        else if (is_mem_wr) state_d = ST_LOAD;
        else                state_d = ST_CMD;
      end
      ST_LOAD: begin
        o_wr_ready = (buf_count < chunk);
        if (buf_count == chunk) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (!i_tx_full) begin
          o_tx_write = 1'b1;
          o_tx_data  = cmd_word[{byte_q, 3'b000} +: 8];
          if (byte_q == 2'd3) begin
            if (is_mem_wr)                    state_d = ST_PAYLOAD;
            else if (req_q.cmd == CMD_READ)   state_d = ST_RESP;
            else                              state_d = ST_DONE;
          end
        end
      end
      ST_PAYLOAD: begin
        o_tx_write = buf_pop;
        o_tx_data  = buf_data;
        if (chunk_end) state_d = last_chunk ? ST_DONE : ST_LOAD;
      end
      ST_RESP: begin
        o_rx_read = rx_pop;
        if (chunk_end)    state_d = last_chunk ? ST_DONE : ST_CMD;
        else if (tmo_hit) state_d = ST_DONE;
      end
      ST_DONE: begin
        o_done  = 1'b1;
        o_err   = err_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      addr_q    <= '0;
      rem_q     <= '0;
      byte_q    <= '0;
      rd_cnt_q  <= '0;
      err_q     <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_vld_q <= rx_pop;
      if (rx_pop) rd_data_q <= i_rx_data;
      case (state_q)
        ST_IDLE: if (i_req_valid) begin
          req_q <= '{cmd: i_req_cmd, addr: i_req_addr, size: i_req_size};
          err_q <= 1'b0;
        end
        ST_CHECK: begin
          rem_q  <= 15'(req_q.size) + 15'd1;
          addr_q <= req_q.addr[12:0];
          err_q  <= bad_req;
          byte_q <= '0;
        end
        ST_CMD: begin
          if (o_tx_write) byte_q <= byte_q + 1'b1;
          rd_cnt_q <= '0;
        end
        ST_RESP: begin
          if (rx_pop)  rd_cnt_q <= rd_cnt_q + 1'b1;
          if (tmo_hit) err_q    <= 1'b1;
        end
        default: ;
      endcase
      // the 15-bit remaining count never goes below zero: chunk <= rem_q by construction
      if (chunk_end) begin
        rem_q    <= rem_q - 15'(chunk);
        addr_q   <= addr_q + 13'(chunk);
        rd_cnt_q <= '0;
      end
    end
  end

  assign o_rd_valid = rd_vld_q;
  assign o_rd_data  = rd_data_q;

endmodule

// File: tb/tb_host_cmd_initiator.sv
// Scoreboard bench for host_cmd_initiator: a device model feeds/collects FIFO bytes.
module tb_host_cmd_initiator;
  logic        i_clk = 1'b0, i_rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic [3:0]  i_req_cmd = '0;
  logic [13:0] i_req_addr = '0, i_req_size = '0;
  logic        i_wr_valid, i_tx_full = 1'b0, i_rx_empty;
  logic [7:0]  i_wr_data, i_rx_data;
  logic        o_req_ready, o_wr_ready, o_tx_write, o_rx_read, o_rd_valid, o_done, o_err;
  logic [7:0]  o_tx_data, o_rd_data;

  int checks = 0, passes = 0, done_cnt = 0, tx_cnt = 0;
  logic [7:0] tx_exp_q[$], rd_exp_q[$], rx_q[$], wr_q[$];
  logic [7:0] tx_e, rd_e;

  always #5 i_clk = ~i_clk;

  host_cmd_initiator #(.MAX_BURST(16), .TIMEOUT_CYCLES(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_cmd(i_req_cmd), .i_req_addr(i_req_addr), .i_req_size(i_req_size),
    .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data), .o_wr_ready(o_wr_ready),
    .o_tx_write(o_tx_write), .o_tx_data(o_tx_data), .i_tx_full(i_tx_full),
    .o_rx_read(o_rx_read), .i_rx_data(i_rx_data), .i_rx_empty(i_rx_empty),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
    .o_done(o_done), .o_err(o_err)
  );

  // expected command word: {id, addr, size} sent LSB byte first
  function automatic void push_cmd(input int id, input int addr, input int size);
    logic [31:0] w;
    w = (32'(id) << 28) | (32'(addr) << 14) | 32'(size);
    for (int i = 0; i < 4; i++) tx_exp_q.push_back(w[8*i +: 8]);
  endfunction

  // scoreboard: every byte the DUT emits is compared against the expected queue
  always @(negedge i_clk) begin
    if (o_tx_write) begin
      tx_cnt++;
      checks++;
      if (i_tx_full) $display("FAIL tx_while_full got write=1 required 0");
      else if (tx_exp_q.size() == 0) $display("FAIL tx_extra got %02h required no byte", o_tx_data);
      else begin
        tx_e = tx_exp_q.pop_front();
        if (o_tx_data !== tx_e) $display("FAIL tx_byte got %02h required %02h", o_tx_data, tx_e);
        else passes++;
      end
    end
    if (o_rd_valid) begin
      checks++;
      if (rd_exp_q.size() == 0) $display("FAIL rd_extra got %02h required no byte", o_rd_data);
      else begin
        rd_e = rd_exp_q.pop_front();
        if (o_rd_data !== rd_e) $display("FAIL rd_byte got %02h required %02h", o_rd_data, rd_e);
        else passes++;
      end
    end
    if (o_done) done_cnt++;
  end

  // device output FIFO and host payload source
  initial begin
    bit rx_pop, wr_pop;
    i_rx_empty = 1'b1; i_rx_data = '0; i_wr_valid = 1'b0; i_wr_data = '0;
    forever begin
      @(negedge i_clk);
      rx_pop = o_rx_read;
      wr_pop = i_wr_valid && o_wr_ready;
      @(posedge i_clk); #1;
      if (rx_pop && rx_q.size() > 0) void'(rx_q.pop_front());
      if (wr_pop && wr_q.size() > 0) void'(wr_q.pop_front());
      i_rx_empty = (rx_q.size() == 0);
      i_rx_data  = i_rx_empty ? 8'h00 : rx_q[0];
      i_wr_valid = (wr_q.size() > 0);
      i_wr_data  = i_wr_valid ? wr_q[0] : 8'h00;
    end
  end

  task automatic send_req(input logic [3:0] cmd, input logic [13:0] addr, input logic [13:0] size);
    int n = 0;
    @(posedge i_clk); #1;
    i_req_valid = 1'b1; i_req_cmd = cmd; i_req_addr = addr; i_req_size = size;
    do begin @(negedge i_clk); n++; end while (!o_req_ready && n < 50);
    if (!o_req_ready) begin
      checks++;
      $display("FAIL req_accept got ready=0 required 1 within 50 cycles");
    end
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output bit got, output bit err, output int cyc);
    got = 0; err = 0; cyc = 0;
    while (!got && cyc < maxc) begin
      @(negedge i_clk); cyc++;
      if (o_done) begin got = 1; err = o_err; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    checks++;
    if (o_req_ready !== 1'b1) $display("FAIL reset_ready got %b required 1", o_req_ready);
    else passes++;
    checks++;
    if ({o_tx_write, o_wr_ready, o_rx_read, o_rd_valid, o_done, o_err, o_tx_data, o_rd_data} !== 22'd0)
      $display("FAIL reset_outputs got %h required 0",
               {o_tx_write, o_wr_ready, o_rx_read, o_rd_valid, o_done, o_err, o_tx_data, o_rd_data});
    else passes++;
    @(posedge i_clk); #1; i_rst = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_req_ready !== 1'b1) $display("FAIL post_reset_ready got %b required 1", o_req_ready);
    else passes++;
  endtask

  task automatic test_write();
    bit got, err; int cyc, d0;
    logic [7:0] pl[4];
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    d0 = done_cnt;
    push_cmd(2, 'h010, 3);
    foreach (pl[i]) begin wr_q.push_back(pl[i]); tx_exp_q.push_back(pl[i]); end
    send_req(4'd2, 14'h010, 14'd3);
    wait_done(100, got, err, cyc);
    repeat (3) @(negedge i_clk);
    checks++;
    if (!got || err) $display("FAIL write_done got done=%0b err=%0b required 1 0", got, err);
    else passes++;
    checks++;
    if (tx_exp_q.size() != 0 || done_cnt - d0 != 1)
      $display("FAIL write_complete got left=%0d dones=%0d required 0 1", tx_exp_q.size(), done_cnt - d0);
    else passes++;
  endtask

  task automatic test_write_chunked();
    bit got, err; int cyc;
    logic [7:0] b;
    push_cmd(2, 'h100, 15);
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom_range(0, 255));
      wr_q.push_back(b);
      tx_exp_q.push_back(b);
      if (i == 15) push_cmd(2, 'h110, 3);
    end
    send_req(4'd2, 14'h100, 14'd19);
    wait_done(300, got, err, cyc);
    repeat (2) @(negedge i_clk);
    checks++;
    if (!got || err || tx_exp_q.size() != 0)
      $display("FAIL write_chunked got done=%0b err=%0b left=%0d required 1 0 0", got, err, tx_exp_q.size());
    else passes++;
  endtask

  task automatic test_read_chunked();
    bit got, err; int cyc, d0;
    logic [7:0] b;
    d0 = done_cnt;
    push_cmd(1, 0, 15);
    push_cmd(1, 16, 3);
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom_range(0, 255));
      rx_q.push_back(b);
      rd_exp_q.push_back(b);
    end
    send_req(4'd1, 14'h000, 14'd19);
    wait_done(300, got, err, cyc);
    repeat (3) @(negedge i_clk);
    checks++;
    if (!got || err) $display("FAIL read_done got done=%0b err=%0b required 1 0", got, err);
    else passes++;
    checks++;
    if (tx_exp_q.size() != 0 || rd_exp_q.size() != 0 || done_cnt - d0 != 1)
      $display("FAIL read_complete got tx_left=%0d rd_left=%0d dones=%0d required 0 0 1",
               tx_exp_q.size(), rd_exp_q.size(), done_cnt - d0);
    else passes++;
  endtask

  task automatic test_reg();
    bit got, err; int cyc;
    push_cmd(2, 'h2000, 1);
    send_req(4'd2, 14'h2000, 14'h001);
    wait_done(50, got, err, cyc);
    repeat (2) @(negedge i_clk);
    checks++;
    if (!got || err || tx_exp_q.size() != 0)
      $display("FAIL reg_write got done=%0b err=%0b left=%0d required 1 0 0", got, err, tx_exp_q.size());
    else passes++;
    push_cmd(1, 'h2000, 0);
    rx_q.push_back(8'h01); rx_q.push_back(8'hEE);
    rd_exp_q.push_back(8'h01);
    send_req(4'd1, 14'h2000, 14'h000);
    wait_done(50, got, err, cyc);
    repeat (2) @(negedge i_clk);
    checks++;
    if (!got || err || rd_exp_q.size() != 0 || rx_q.size() != 1)
      $display("FAIL reg_read got done=%0b err=%0b rd_left=%0d rx_left=%0d required 1 0 0 1",
               got, err, rd_exp_q.size(), rx_q.size());
    else passes++;
    rx_q.delete();
  endtask

  task automatic test_bad_range();
    bit got, err; int cyc, t0;
    t0 = tx_cnt;
    send_req(4'd1, 14'h1FFF, 14'd1);
    wait_done(20, got, err, cyc);
    checks++;
    if (!got || !err || tx_cnt != t0)
      $display("FAIL bad_range got done=%0b err=%0b tx=%0d required 1 1 0", got, err, tx_cnt - t0);
    else passes++;
    push_cmd(1, 'h1FFF, 0);
    rx_q.push_back(8'h5C); rd_exp_q.push_back(8'h5C);
    send_req(4'd1, 14'h1FFF, 14'd0);
    wait_done(50, got, err, cyc);
    repeat (2) @(negedge i_clk);
    checks++;
    if (!got || err || tx_exp_q.size() != 0 || rd_exp_q.size() != 0)
      $display("FAIL edge_range got done=%0b err=%0b tx_left=%0d rd_left=%0d required 1 0 0 0",
               got, err, tx_exp_q.size(), rd_exp_q.size());
    else passes++;
  endtask

  task automatic test_back_to_back();
    bit got, err; int cyc, t0, n;
    t0 = tx_cnt;
    send_req(4'd7, 14'h0, 14'h0);
    n = 0;
    while (!o_done && n < 20) begin @(negedge i_clk); n++; end
    checks++;
    if (o_done !== 1'b1 || o_err !== 1'b1 || tx_cnt != t0)
      $display("FAIL bad_cmd got done=%b err=%b tx=%0d required 1 1 0", o_done, o_err, tx_cnt - t0);
    else passes++;
    push_cmd(2, 'h2000, 'h5A);
    i_req_valid = 1'b1; i_req_cmd = 4'd2; i_req_addr = 14'h2000; i_req_size = 14'h05A;
    checks++;
    if (o_req_ready !== 1'b0) $display("FAIL ready_in_done got %b required 0", o_req_ready);
    else passes++;
    @(negedge i_clk);
    checks++;
    if (o_req_ready !== 1'b1) $display("FAIL ready_after_done got %b required 1", o_req_ready);
    else passes++;
    @(posedge i_clk); #1; i_req_valid = 1'b0;
    wait_done(50, got, err, cyc);
    repeat (2) @(negedge i_clk);
    checks++;
    if (!got || err || tx_exp_q.size() != 0)
      $display("FAIL queued_req got done=%0b err=%0b left=%0d required 1 0 0", got, err, tx_exp_q.size());
    else passes++;
  endtask

  task automatic test_tx_full();
    bit got, err; int cyc, t0, n;
    t0 = tx_cnt;
    push_cmd(1, 'h100, 1);
    rx_q.push_back(8'hA1); rx_q.push_back(8'hB2);
    rd_exp_q.push_back(8'hA1); rd_exp_q.push_back(8'hB2);
    send_req(4'd1, 14'h100, 14'd1);
    n = 0;
    while (tx_cnt == t0 && n < 20) begin @(negedge i_clk); n++; end
    @(posedge i_clk); #1; i_tx_full = 1'b1;
    repeat (5) @(posedge i_clk);
    #1; i_tx_full = 1'b0;
    wait_done(100, got, err, cyc);
    repeat (2) @(negedge i_clk);
    checks++;
    if (!got || err || tx_cnt - t0 != 4 || tx_exp_q.size() != 0 || rd_exp_q.size() != 0)
      $display("FAIL tx_full_stall got done=%0b err=%0b tx=%0d rd_left=%0d required 1 0 4 0",
               got, err, tx_cnt - t0, rd_exp_q.size());
    else passes++;
  endtask

  task automatic test_reset_mid_payload();
    bit got, err; int cyc, n;
    push_cmd(2, 'h040, 3);
    for (int i = 0; i < 4; i++) begin
      wr_q.push_back(8'(8'hC0 + i)); tx_exp_q.push_back(8'(8'hC0 + i));
    end
    send_req(4'd2, 14'h040, 14'd3);
    n = 0;
    while (tx_exp_q.size() > 2 && n < 100) begin @(negedge i_clk); n++; end
    @(posedge i_clk); #1; i_rst = 1'b1;
    #1;
    checks++;
    if ({o_tx_write, o_wr_ready, o_rx_read, o_rd_valid, o_done, o_err} !== 6'd0)
      $display("FAIL reset_mid_payload got %b required 000000",
               {o_tx_write, o_wr_ready, o_rx_read, o_rd_valid, o_done, o_err});
    else passes++;
    tx_exp_q.delete(); wr_q.delete();
    repeat (2) @(posedge i_clk);
    #1; i_rst = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_req_ready !== 1'b1) $display("FAIL ready_after_rst got %b required 1", o_req_ready);
    else passes++;
    push_cmd(0, 0, 0);
    send_req(4'd0, 14'h0, 14'h0);
    wait_done(50, got, err, cyc);
    repeat (2) @(negedge i_clk);
    checks++;
    if (!got || err || tx_exp_q.size() != 0)
      $display("FAIL reset_cmd got done=%0b err=%0b left=%0d required 1 0 0", got, err, tx_exp_q.size());
    else passes++;
  endtask

`ifdef CMD_INIT_TIMEOUT_EN
  task automatic test_timeout();
    bit got, err; int cyc;
    push_cmd(1, 0, 3);
    rx_q.push_back(8'hAB); rd_exp_q.push_back(8'hAB);
    send_req(4'd1, 14'h000, 14'd3);
    wait_done(60, got, err, cyc);
    checks++;
    if (!got || !err || cyc < 13 || cyc > 17)
      $display("FAIL timeout got done=%0b err=%0b cycles=%0d required 1 1 13..17", got, err, cyc);
    else passes++;
    repeat (2) @(negedge i_clk);
    rx_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_write_chunked();
    test_read_chunked();
    test_reg();
    test_bad_range();
    test_back_to_back();
    test_tx_full();
    test_reset_mid_payload();
`ifdef CMD_INIT_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
